neuron_mac_seq: RTL and testbench

Parametrised, pipelined multiply-accumulate neuron for the DNN/GNN datapaths. Each beat accepts LANES signed input/weight pairs. Products are accumulated over a variable number of beats (up to MAX_BEATS) per output. The block then adds a bias, optionally applies ReLU, and saturates to OUT_W. A valid/ready handshake sits on both sides with a single output holding register, so the block sustains back-to-back vectors and tolerates downstream stalls.

---
 rtl/neuron_mac_seq.sv | 161 ++++++++++++++++
 tb/tb_neuron_mac_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_seq.sv
// Pipelined multiply-accumulate neuron: LANES products per beat, accumulated over
// up to MAX_BEATS beats, then bias, optional ReLU and saturation to OUT_W.
module neuron_mac_seq #(
  parameter int IN_W      = 5,
  parameter int W_W       = 5,
  parameter int LANES     = 4,
  parameter int MAX_BEATS = 4,
  parameter int OUT_W     = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*IN_W-1:0]   in_data,
  input  logic [LANES*W_W-1:0]    in_wgt,
  input  logic                    in_last,
  input  logic [OUT_W-1:0]        bias,
  input  logic                    relu_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        result,
  output logic                    out_sat,
  output logic                    out_ovf
);

  localparam int PROD_W = IN_W + W_W;
  localparam int TREE_W = PROD_W + $clog2(LANES * MAX_BEATS) + 1;
  localparam int ACC_W  = ((TREE_W > OUT_W) ? TREE_W : OUT_W) + 1;
  localparam int CNT_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                    en_s;
  logic                    accept_s;
  logic                    first_s;
  logic                    end_s;
  logic                    ovf_s;
  logic [CNT_W-1:0]        cnt_r;

  logic signed [ACC_W-1:0] prod_s [LANES];
  logic signed [ACC_W-1:0] s1_prod_r [LANES];
  logic                    s1_valid_r;
  logic                    s1_first_r;
  logic                    s1_end_r;
  logic                    s1_ovf_r;
  logic                    s1_relu_r;
  logic signed [OUT_W-1:0] s1_bias_r;

  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W-1:0] base_s;
  logic signed [ACC_W-1:0] v_s;
  logic signed [ACC_W-1:0] relu_v_s;
  logic        [OUT_W-1:0] clip_s;
  logic                    sat_s;

  assign en_s     = !out_valid | out_ready;
  assign in_ready = en_s;
  assign accept_s = in_valid & en_s;
  assign first_s  = (cnt_r == {CNT_W{1'b0}});
  assign end_s    = in_last | (cnt_r == CNT_W'(MAX_BEATS - 1));
  // A single-beat configuration always ends on in_last semantics, never by force.
  assign ovf_s    = (MAX_BEATS > 1) & !in_last & (cnt_r == CNT_W'(MAX_BEATS - 1));

  // Per-lane signed products, sign-extended to the accumulator width.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod_s[k] = ACC_W'($signed(in_data[k*IN_W +: IN_W]) * $signed(in_wgt[k*W_W +: W_W]));
    end
  end

  // Accumulate base, ReLU and clip for the beat held in S1.
  always_comb begin
    sum_s = {ACC_W{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      sum_s = sum_s + s1_prod_r[k];
    end
    base_s = s1_first_r ? ACC_W'(s1_bias_r) : acc_r;
    v_s    = base_s + sum_s;
    if (s1_relu_r && (v_s < $signed({ACC_W{1'b0}}))) begin
      relu_v_s = {ACC_W{1'b0}};
    end else begin
      relu_v_s = v_s;
    end
    if (relu_v_s > OUT_MAX) begin
      clip_s = OUT_MAX[OUT_W-1:0];
      sat_s  = 1'b1;
    end else if (relu_v_s < OUT_MIN) begin
      clip_s = OUT_MIN[OUT_W-1:0];
      sat_s  = 1'b1;
    end else begin
      clip_s = relu_v_s[OUT_W-1:0];
      sat_s  = 1'b0;
    end
  end

  // Beat counter: restarts after every vector-ending beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      cnt_r <= end_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Stage 1: register products and vector tags of the accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        s1_prod_r[k] <= {ACC_W{1'b0}};
      end
      s1_valid_r <= 1'b0;
      s1_first_r <= 1'b0;
      s1_end_r   <= 1'b0;
      s1_ovf_r   <= 1'b0;
      s1_relu_r  <= 1'b0;
      s1_bias_r  <= {OUT_W{1'b0}};
    end else if (en_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        for (int k = 0; k < LANES; k++) begin
          s1_prod_r[k] <= prod_s[k];
        end
        s1_first_r <= first_s;
        s1_end_r   <= end_s;
        s1_ovf_r   <= ovf_s;
        s1_relu_r  <= relu_en;
        if (first_s) begin
          s1_bias_r <= bias;
        end
      end
    end
  end

  // Stage 2: accumulator update and output holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= {ACC_W{1'b0}};
      out_valid <= 1'b0;
      result    <= {OUT_W{1'b0}};
      out_sat   <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      if (en_s && s1_valid_r) begin
        acc_r <= v_s;
      end
      if (en_s && s1_valid_r && s1_end_r) begin
        out_valid <= 1'b1;
        result    <= clip_s;
        out_sat   <= sat_s;
        out_ovf   <= s1_ovf_r;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Randomized and directed bench for neuron_mac_seq against an integer reference model.
module tb_neuron_mac_seq;

  localparam int IN_W      = 5;
  localparam int W_W       = 5;
  localparam int LANES     = 4;
  localparam int MAX_BEATS = 4;
  localparam int OUT_W     = 12;
  localparam int OMAX      = (1 << (OUT_W - 1)) - 1;
  localparam int OMIN      = -(1 << (OUT_W - 1));

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*IN_W-1:0] in_data;
  logic [LANES*W_W-1:0]  in_wgt;
  logic                  in_last;
  logic [OUT_W-1:0]      bias;
  logic                  relu_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      result;
  logic                  out_sat;
  logic                  out_ovf;

  neuron_mac_seq #(
    .IN_W(IN_W), .W_W(W_W), .LANES(LANES), .MAX_BEATS(MAX_BEATS), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_wgt(in_wgt), .in_last(in_last), .bias(bias),
    .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_sat(out_sat), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int res;
    int sat;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_cnt    = 0;
  int   m_acc    = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [LANES*IN_W-1:0] pk_d(input int a0, a1, a2, a3);
    return {IN_W'(a3), IN_W'(a2), IN_W'(a1), IN_W'(a0)};
  endfunction

  function automatic logic [LANES*W_W-1:0] pk_w(input int a0, a1, a2, a3);
    return {W_W'(a3), W_W'(a2), W_W'(a1), W_W'(a0)};
  endfunction

  // Reference: integer dot product, running vector sum, ReLU and clamp.
  task automatic model_accept(input logic [LANES*IN_W-1:0] d, input logic [LANES*W_W-1:0] w,
                              input logic last, input logic [OUT_W-1:0] b, input logic relu);
    logic signed [IN_W-1:0]  a;
    logic signed [W_W-1:0]   g;
    logic signed [OUT_W-1:0] sb;
    int   dot;
    int   v;
    bit   vend;
    exp_t e;
    dot = 0;
    for (int k = 0; k < LANES; k++) begin
      a = d[k*IN_W +: IN_W];
      g = w[k*W_W +: W_W];
      dot += int'(a) * int'(g);
    end
    sb = b;
    if (m_cnt == 0) m_acc = int'(sb);
    m_acc += dot;
    vend = last || (m_cnt == MAX_BEATS - 1);
    if (vend) begin
      v = m_acc;
      if (relu && v < 0) v = 0;
      e.sat = (v > OMAX || v < OMIN) ? 1 : 0;
      e.res = (v > OMAX) ? OMAX : (v < OMIN) ? OMIN : v;
      e.ovf = (!last && MAX_BEATS > 1) ? 1 : 0;
      exp_q.push_back(e);
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  // Scoreboard: every consumed result must match the head of the model queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_result", int'(out_valid), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("result", int'($signed(result)), mon_e.res);
        check_eq("out_sat", int'(out_sat), mon_e.sat);
        check_eq("out_ovf", int'(out_ovf), mon_e.ovf);
      end
    end
  end

  // Offer one beat; called and returns at posedge+1.
  task automatic send_beat(input logic [LANES*IN_W-1:0] d, input logic [LANES*W_W-1:0] w,
                           input logic last, input logic [OUT_W-1:0] b, input logic relu,
                           input bit rnd);
    int waited;
    waited   = 0;
    in_data  = d;
    in_wgt   = w;
    in_last  = last;
    bias     = b;
    relu_en  = relu;
    in_valid = 1'b1;
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check_eq("accept_timeout", int'(in_ready), 1);
    else model_accept(d, w, last, b, relu);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_wgt    = '0;
    in_last   = 1'b0;
    bias      = '0;
    relu_en   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_result", int'(result), 0);
    check_eq("rst_sat_ovf", int'({out_sat, out_ovf}), 0);
    @(posedge clk); #1;

    // Single beat with latency check
    send_beat(pk_d(1, 2, 3, 4), pk_w(1, 1, 1, 1), 1'b1, 12'sd0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("lat_cycle1", int'(out_valid), 0);
    @(negedge clk);
    check_eq("lat_cycle2", int'(out_valid), 1);
    check_eq("single_result", int'($signed(result)), 10);
    @(posedge clk); #1;
    drain();

    // Positive saturation, then ReLU off/on
    send_beat(pk_d(-16, -16, -16, -16), pk_w(-16, -16, -16, -16), 1'b0, 12'sd0, 1'b0, 1'b0);
    send_beat(pk_d(-16, -16, -16, -16), pk_w(-16, -16, -16, -16), 1'b1, 12'sd0, 1'b0, 1'b0);
    send_beat(pk_d(1, 1, 1, 1), pk_w(-3, -3, -3, -3), 1'b1, -12'sd2, 1'b0, 1'b0);
    send_beat(pk_d(1, 1, 1, 1), pk_w(-3, -3, -3, -3), 1'b1, -12'sd2, 1'b1, 1'b0);
    drain();

    // Forced termination after MAX_BEATS, then a fresh vector
    for (int i = 0; i < 5; i++) begin
      send_beat(pk_d(1, 0, 0, 0), pk_w(1, 0, 0, 0), (i == 4), 12'sd0, 1'b0, 1'b0);
    end
    drain();

    // Backpressure: result 10 held while vector 2 waits
    out_ready = 1'b0;
    send_beat(pk_d(1, 2, 3, 4), pk_w(1, 1, 1, 1), 1'b1, 12'sd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_data  = pk_d(1, 1, 1, 1);
    in_wgt   = pk_w(2, 2, 2, 2);
    in_last  = 1'b1;
    bias     = 12'sd0;
    relu_en  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", int'(in_ready), 0);
      check_eq("bp_hold", int'($signed(result)), 10);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    if (in_ready) model_accept(in_data, in_wgt, in_last, bias, relu_en);
    check_eq("bp_release", int'(in_ready), 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check_eq("bp_lat1", int'(out_valid), 0);
    @(negedge clk);
    check_eq("bp_lat2", int'(out_valid), 1);
    check_eq("bp_v2", int'($signed(result)), 8);
    @(posedge clk); #1;
    drain();

    // Reset in the middle of a vector discards the partial sum
    send_beat(pk_d(5, 5, 5, 5), pk_w(5, 5, 5, 5), 1'b0, 12'sd100, 1'b0, 1'b0);
    send_beat(pk_d(5, 5, 5, 5), pk_w(5, 5, 5, 5), 1'b0, 12'sd100, 1'b0, 1'b0);
    rst_n = 1'b0;
    m_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    send_beat(pk_d(2, 0, 0, 0), pk_w(3, 0, 0, 0), 1'b1, 12'sd1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("midrst_result", int'($signed(result)), 7);
    drain();

    // Random vectors with random stalls and bubbles
    for (int i = 0; i < 400; i++) begin
      send_beat(LANES*IN_W'($urandom), LANES*W_W'($urandom), ($urandom_range(0, 2) == 0),
                OUT_W'($urandom), 1'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 1) != 0);
        end
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
